// File: rtl/bank_queue_counter.sv
// bank_queue_counter: synchronizes door sensors, keeps a saturating queue count
// and derives the per-teller estimated wait time.
module bank_queue_counter #(
  parameter int n           = 3,
  parameter int P_COUNT_MAX = (1 << (n + 1)) - 1,
  parameter int P_WAIT_MAX  = 3 * P_COUNT_MAX,
  parameter int WTIME_WIDTH = $clog2(P_WAIT_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   back_sensor,
  input  logic                   front_sensor,
  input  logic [1:0]             Tcount,
  output logic [n:0]             Pcount,
  output logic [WTIME_WIDTH:0]   Pwait,
  output logic                   full,
  output logic                   empty
);
  localparam int W = WTIME_WIDTH + 2;
  // bit0 = sync1, bit1 = sync2, bit2 = previous sync2
  logic [2:0] back_q, front_q;
  logic enter, leave;
  logic [n:0] next_count;
  logic [1:0] tellers;
  logic [W-1:0] num, wait_calc;
  assign enter = back_q[1] & ~back_q[2];
  assign leave = front_q[1] & ~front_q[2];
  assign tellers = (Tcount == 2'd0) ? 2'd1 : Tcount;
  always_comb begin
    next_count = (enter == leave) ? Pcount :
                 enter ? (full ? Pcount : Pcount + 1'b1) :
                 (empty ? Pcount : Pcount - 1'b1);
    num = W'(3) * (W'(Pcount) + W'(tellers) - W'(1));
    wait_calc = (Pcount == '0) ? '0 :
                (tellers == 2'd2) ? (num >> 1) :
                (tellers == 2'd3) ? (num / W'(3)) : num;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_q  <= '0;
      front_q <= '0;
      Pcount  <= '0;
      Pwait   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      back_q  <= {back_q[1:0], back_sensor};
      front_q <= {front_q[1:0], front_sensor};
      Pcount  <= next_count;
      full    <= next_count == (n + 1)'(P_COUNT_MAX);
      empty   <= next_count == '0;
      Pwait   <= wait_calc[WTIME_WIDTH:0];
    end
  end
endmodule

// File: tb/tb_bank_queue_counter.sv
// tb_bank_queue_counter: directed scoreboard bench for bank_queue_counter.
module tb_bank_queue_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic back_sensor = 1'b0;
  logic front_sensor = 1'b0;
  logic [1:0] Tcount = 2'd1;
  logic [3:0] Pcount;
  logic [6:0] Pwait;
  logic full, empty;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    string tag;
    logic [12:0] v;
  } item_t;
  item_t sb[$];

  bank_queue_counter dut (
    .clk(clk), .rst_n(rst_n), .back_sensor(back_sensor), .front_sensor(front_sensor),
    .Tcount(Tcount), .Pcount(Pcount), .Pwait(Pwait), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic want(input string tag, input int pc, input int pw, input logic f, input logic e);
    sb.push_back('{tag, {4'(pc), 7'(pw), f, e}});
  endtask

  task automatic check();
    item_t it;
    logic [12:0] obs;
    vectors++;
    obs = {Pcount, Pwait, full, empty};
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %h, expected a queued vector", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.v) else begin
        miscompares++;
        $error("FAIL %s: got Pcount=%0d Pwait=%0d full=%b empty=%b, expected Pcount=%0d Pwait=%0d full=%b empty=%b",
               it.tag, obs[12:9], obs[8:2], obs[1], obs[0], it.v[12:9], it.v[8:2], it.v[1], it.v[0]);
      end
    end
  endtask

  task automatic expect_now(input string tag, input int pc, input int pw, input logic f, input logic e);
    want(tag, pc, pw, f, e);
    check();
  endtask

  task automatic add(input int k);
    for (int i = 0; i < k; i++) begin
      back_sensor = 1'b1;
      tick(1);
      back_sensor = 1'b0;
      tick(1);
    end
    tick(4);
  endtask

  task automatic sub(input int k);
    for (int i = 0; i < k; i++) begin
      front_sensor = 1'b1;
      tick(1);
      front_sensor = 1'b0;
      tick(1);
    end
    tick(4);
  endtask

  task automatic both();
    back_sensor = 1'b1;
    front_sensor = 1'b1;
    tick(1);
    back_sensor = 1'b0;
    front_sensor = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    tick(3);
    expect_now("reset_held", 0, 0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      expect_now("idle", 0, 0, 1'b0, 1'b1);
    end
    // single enter: expectations queued as the stimulus is applied
    back_sensor = 1'b1;
    want("enter_e1", 0, 0, 1'b0, 1'b1);
    want("enter_e2", 0, 0, 1'b0, 1'b1);
    want("enter_e3", 1, 0, 1'b0, 1'b0);
    want("enter_e4", 1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check();
    end
    tick(1);
    back_sensor = 1'b0;
    tick(4);
    expect_now("enter_once", 1, 3, 1'b0, 1'b0);
    add(6);
    expect_now("load7_t1", 7, 21, 1'b0, 1'b0);
    Tcount = 2'd2;
    tick(1);
    expect_now("load7_t2", 7, 12, 1'b0, 1'b0);
    Tcount = 2'd3;
    tick(1);
    expect_now("load7_t3", 7, 9, 1'b0, 1'b0);
    Tcount = 2'd0;
    tick(1);
    expect_now("load7_t0", 7, 21, 1'b0, 1'b0);
    Tcount = 2'd1;
    do_reset();
    add(17);
    expect_now("saturate", 15, 45, 1'b1, 1'b0);
    Tcount = 2'd2;
    tick(1);
    expect_now("full_t2", 15, 24, 1'b1, 1'b0);
    Tcount = 2'd3;
    tick(1);
    expect_now("full_t3", 15, 17, 1'b1, 1'b0);
    Tcount = 2'd1;
    sub(16);
    expect_now("underflow", 0, 0, 1'b0, 1'b1);
    add(5);
    expect_now("load5", 5, 15, 1'b0, 1'b0);
    both();
    expect_now("both_at5", 5, 15, 1'b0, 1'b0);
    do_reset();
    both();
    expect_now("both_at0", 0, 0, 1'b0, 1'b1);
    add(15);
    expect_now("load15", 15, 45, 1'b1, 1'b0);
    both();
    expect_now("both_at15", 15, 45, 1'b1, 1'b0);
    do_reset();
    add(9);
    expect_now("load9", 9, 27, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expect_now("async_reset", 0, 0, 1'b0, 1'b1);
    back_sensor = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    expect_now("rel_e2", 0, 0, 1'b0, 1'b1);
    tick(1);
    expect_now("rel_e3", 1, 0, 1'b0, 1'b0);
    tick(1);
    expect_now("rel_e4", 1, 3, 1'b0, 1'b0);
    back_sensor = 1'b0;
    tick(3);
    expect_now("rel_hold", 1, 3, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
